// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, default frame geometry, parity helper.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Parity bit that accompanies data; narrower payloads are zero-extended, which leaves XOR intact.
  function automatic logic parity_calc(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for rxd plus a delayed copy for falling-edge detection.
module uart_rx_sync (
  input  logic clk16x,
  input  logic clr,
  input  logic rxd,
  output logic rxs,
  output logic fall
);

  logic meta_q, rxs_q, rxs_d_q;

  // Synchronizer chain; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk16x) begin
    if (clr) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      rxs_d_q <= 1'b1;
    end else begin
      meta_q  <= rxd;
      rxs_q   <= meta_q;
      rxs_d_q <= rxs_q;
    end
  end

  assign rxs  = rxs_q;
  assign fall = rxs_d_q & ~rxs_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deframer with ready/read handshake and status flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned PARITY_ODD = 1,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk16x,
  input  logic                 clr,
  input  logic                 rxd,
  input  logic                 rdn,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 r_ready,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 receiving
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TickHalf = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TickLast = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BitLast  = BW'(DATA_BITS - 1);

  logic rxs, fall;

  uart_rx_sync u_sync (
    .clk16x (clk16x),
    .clr    (clr),
    .rxd    (rxd),
    .rxs    (rxs),
    .fall   (fall)
  );

  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 load;

  logic [DATA_BITS-1:0] d_out_q, d_out_d;
  logic                 r_ready_q, r_ready_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  // Frame FSM next state: counts ticks per bit and samples rxs at bit centres.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (tick_q == TickHalf) begin
          tick_d  = '0;
          bit_d   = '0;
          // A start bit that is high again at its centre was a glitch.
          state_d = rxs ? IDLE : DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DATA: begin
        if (tick_q == TickLast) begin
          tick_d  = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BitLast) state_d = PARITY;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      PARITY: begin
        if (tick_q == TickLast) begin
          tick_d  = '0;
          par_d   = rxs;
          state_d = STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      STOP: begin
        if (tick_q == TickLast) begin
          tick_d  = '0;
          load    = 1'b1;
          // Back to IDLE immediately so a following start edge is not missed.
          state_d = IDLE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/status next state; a frame completion takes priority over a coincident read.
  always_comb begin
    d_out_d   = d_out_q;
    r_ready_d = r_ready_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    if (load) begin
      d_out_d   = shift_q;
      perr_d    = par_q ^ parity_calc(32'(shift_q), PARITY_ODD != 0);
      ferr_d    = ~rxs;
      r_ready_d = 1'b1;
      if (!rdn)           ovr_d = 1'b0;
      else if (r_ready_q) ovr_d = 1'b1;
    end else if (!rdn) begin
      r_ready_d = 1'b0;
      ovr_d     = 1'b0;
    end
  end

  // State and status registers.
  always_ff @(posedge clk16x) begin
    if (clr) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      d_out_q   <= '0;
      r_ready_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      d_out_q   <= d_out_d;
      r_ready_q <= r_ready_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign d_out        = d_out_q;
  assign r_ready      = r_ready_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign overrun      = ovr_q;
  assign receiving    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: nominal, parity/frame errors, glitch, overrun, collision, reset.
module tb_uart_rx;

  logic       clk16x = 1'b0;
  logic       clr    = 1'b1;
  logic       rxd    = 1'b1;
  logic       rdn    = 1'b1;
  logic [7:0] d_out;
  logic       r_ready, parity_error, frame_error, overrun, receiving;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx #(
    .DATA_BITS  (8),
    .PARITY_ODD (1),
    .OVERSAMPLE (16)
  ) dut (
    .clk16x       (clk16x),
    .clr          (clr),
    .rxd          (rxd),
    .rdn          (rdn),
    .d_out        (d_out),
    .r_ready      (r_ready),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .receiving    (receiving)
  );

  always #5 clk16x = ~clk16x;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk16x);
    #1;
  endtask

  // Drives one 11-bit frame, 16 ticks per bit, starting just after a clock edge.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stp);
    logic [10:0] bits;
    bits = {stp, par, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rxd = bits[i];
      tick(16);
    end
  endtask

  task automatic read_pulse();
    rdn = 1'b0;
    tick(1);
    rdn = 1'b1;
  endtask

  initial begin
    tick(4);
    check_eq("rst_d_out", d_out, 0);
    check_eq("rst_r_ready", r_ready, 0);
    check_eq("rst_parity_error", parity_error, 0);
    check_eq("rst_frame_error", frame_error, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_receiving", receiving, 0);
    clr = 1'b0;
    tick(10);

    // Nominal 0xA5: rxd falls after P0, start detected at P3, stop sampled at P171.
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        tick(170);
        check_eq("nom_ready_before", r_ready, 0);
        check_eq("nom_receiving_before", receiving, 1);
        tick(1);
        check_eq("nom_ready_at", r_ready, 1);
        check_eq("nom_receiving_after", receiving, 0);
      end
    join
    check_eq("nom_d_out", d_out, 32'hA5);
    check_eq("nom_perr", parity_error, 0);
    check_eq("nom_ferr", frame_error, 0);
    check_eq("nom_ovr", overrun, 0);
    read_pulse();
    check_eq("nom_read_ready", r_ready, 0);
    check_eq("nom_read_d_out", d_out, 32'hA5);
    tick(20);

    // Parity error: 0x01 under odd parity expects a 0 parity bit.
    send_frame(8'h01, 1'b1, 1'b1);
    check_eq("par_d_out", d_out, 32'h01);
    check_eq("par_perr", parity_error, 1);
    check_eq("par_ferr", frame_error, 0);
    read_pulse();
    tick(20);

    // Frame error: stop bit low, then line held low must not start a second frame.
    send_frame(8'h3C, 1'b1, 1'b0);
    check_eq("fe_d_out", d_out, 32'h3C);
    check_eq("fe_ferr", frame_error, 1);
    check_eq("fe_perr", parity_error, 0);
    check_eq("fe_ready", r_ready, 1);
    tick(200);
    check_eq("fe_hold_receiving", receiving, 0);
    check_eq("fe_hold_ovr", overrun, 0);
    rxd = 1'b1;
    read_pulse();
    tick(20);

    // Glitch: 4-cycle low pulse starts START, centre sample is high, back to IDLE.
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    check_eq("gl_receiving_pulse", receiving, 1);
    tick(20);
    check_eq("gl_receiving_end", receiving, 0);
    check_eq("gl_ready", r_ready, 0);
    tick(10);

    // Overrun: two back-to-back frames with no read.
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    check_eq("ovr_d_out", d_out, 32'h22);
    check_eq("ovr_flag", overrun, 1);
    check_eq("ovr_ready", r_ready, 1);
    check_eq("ovr_perr", parity_error, 0);
    read_pulse();
    check_eq("ovr_read_ready", r_ready, 0);
    check_eq("ovr_read_flag", overrun, 0);
    tick(20);

    // Collision: read coincides with the completion edge of the second frame.
    send_frame(8'h11, 1'b1, 1'b1);
    tick(5);
    fork
      send_frame(8'h22, 1'b1, 1'b1);
      begin
        tick(170);
        rdn = 1'b0;
        tick(1);
        rdn = 1'b1;
      end
    join
    check_eq("col_ready", r_ready, 1);
    check_eq("col_ovr", overrun, 0);
    check_eq("col_d_out", d_out, 32'h22);
    tick(20);

    // Reset during data bit 4 of 0xFF; r_ready is still set from the collision frame.
    fork
      send_frame(8'hFF, 1'b1, 1'b1);
      begin
        tick(88);
        clr = 1'b1;
        tick(1);
        check_eq("clr_d_out", d_out, 0);
        check_eq("clr_ready", r_ready, 0);
        check_eq("clr_receiving", receiving, 0);
        check_eq("clr_ovr", overrun, 0);
        check_eq("clr_perr", parity_error, 0);
        check_eq("clr_ferr", frame_error, 0);
        clr = 1'b0;
      end
    join
    tick(20);
    check_eq("clr_discard_ready", r_ready, 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    check_eq("post_d_out", d_out, 32'h5A);
    check_eq("post_ready", r_ready, 1);
    check_eq("post_perr", parity_error, 0);
    check_eq("post_ferr", frame_error, 0);
    check_eq("post_ovr", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Standalone UART receiver, the receive end of the serial link driven by `uart` transmit logic. It oversamples `rxd` at 16x and deframes start, 8 data bits (LSB first), parity and stop. It presents each byte behind a ready/read handshake with parity, frame and overrun status. It is used wherever only the receive half is needed, and as the checking end in back-to-back link benches.

## Interface
Parameters:
- `DATA_BITS`, 8: payload bits per frame.
- `PARITY_ODD`, 1: 1 selects odd parity, 0 selects even.
- `OVERSAMPLE`, 16: `clk16x` ticks per bit. Must be even and ≥ 8.

Ports. One clock; reset is synchronous and active-high.
- `clk16x`, in, 1: oversampling clock. All logic runs on its rising edge.
- `clr`, in, 1: synchronous, active-high reset.
- `rxd`, in, 1: serial input. Idles high. Asynchronous to `clk16x`.
- `rdn`, in, 1: active-low read strobe.
- `d_out`, out, `DATA_BITS`: last received byte.
- `r_ready`, out, 1: a byte is available.
- `parity_error`, out, 1: parity mismatch on the byte in `d_out`.
- `frame_error`, out, 1: stop bit sampled low on the byte in `d_out`.
- `overrun`, out, 1: a byte was overwritten before it was read.
- `receiving`, out, 1: high in any state other than IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer (reset value 1), giving `rxs`, plus a registered copy `rxs_d`.
- **IDLE**
  - On `rxs_d`=1 and `rxs`=0, go to START and set the tick counter to 0.
  - A line that stays low does not retrigger.
- **START**
  - Count ticks. At count `OVERSAMPLE/2-1`, sample `rxs`.
  - If 0, clear the counter and go to DATA.
  - If 1 (glitch), return to IDLE with no status change.
- **DATA**
  - Sample `rxs` at count `OVERSAMPLE-1` and shift it in, LSB first.
  - After `DATA_BITS` samples, go to PARITY.
- **PARITY**
  - Sample at count `OVERSAMPLE-1`.
  - Expected parity is the XOR of the data bits, inverted when `PARITY_ODD`=1.
- **STOP**
  - Sample at count `OVERSAMPLE-1`, then go to IDLE in the same cycle. This permits back-to-back frames.
  - In the same cycle, load `d_out`, set `parity_error`, set `frame_error` = ~stop sample, and set `r_ready`=1.
  - If `r_ready` was already 1 and no read is occurring in this cycle, set `overrun`=1.
- **Read**
  - Any cycle with `rdn`=0 clears `r_ready` and `overrun` on the next edge.
  - `d_out`, `parity_error` and `frame_error` hold until the next frame completes.
- **Simultaneous load and read**
  - The load wins: `r_ready` stays 1 and `overrun` stays 0.
- **Frame error**
  - The frame is still delivered.
  - The line must return high before a new start can be detected.
- **Reset**
  - `clr`=1 returns to IDLE from any state, including mid-frame. The partial byte is discarded.
  - Reset values: `d_out`=0, `r_ready`=0, `parity_error`=0, `frame_error`=0, `overrun`=0, `receiving`=0.

## Timing
Let E be the edge at which IDLE detects the start condition.
- Start-bit sample: E+8.
- Data bit i (0..7) sample: E+8+16(i+1).
- Parity sample: E+152.
- Stop sample: E+168.
- `r_ready` and status are visible from E+169. `receiving` drops at E+169.
- Raw `rxd` to E: 2–3 cycles of synchronizer latency.
- Minimum frame period for loss-free back-to-back reception: 11 bit times = 176 ticks.
- Tolerated clock mismatch: ±(`OVERSAMPLE/2`−1) ticks of cumulative drift at the stop bit.
- Read: `rdn` low at edge N gives `r_ready`=0 after edge N.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum: IDLE, START, DATA, PARITY, STOP.
  - Default `OVERSAMPLE` and `DATA_BITS` constants.
  - `parity_calc(data, odd)` function, shared with the transmitter.
- Sub-module `uart_rx_sync`: 2-flop synchronizer plus delayed copy. Outputs `rxs` and `fall`.
- The FSM, tick counter, bit counter, shift register and status registers stay in `uart_rx`.

## Test plan
- **Nominal byte.** Frame 0xA5, odd parity bit 1, stop bit 1. Expect `d_out`=0xA5, `r_ready`=1 at E+169, and all error flags 0. Then pulse `rdn` low for 1 cycle: `r_ready`=0 on the next edge and `d_out` still 0xA5.
- **Parity error.** Frame 0x01 with parity bit 1 (odd parity expects 0). Expect `d_out`=0x01, `parity_error`=1, `frame_error`=0.
- **Frame error and glitch.** Frame 0x3C with stop bit 0. Expect `frame_error`=1, `r_ready`=1, and no second frame while the line is held low. Separately, a 4-cycle low glitch on an idle line: `receiving` pulses, then returns to IDLE, and `r_ready` stays 0.
- **Overrun.** Send 0x11 then 0x22 back-to-back with no read. Expect `d_out`=0x22 and `overrun`=1. A read clears both `r_ready` and `overrun`.
- **Read/load collision.** Hold `rdn`=0 on the exact completion edge of a second frame. Expect `r_ready`=1 and `overrun`=0 afterwards.
- **Reset mid-frame.** Assert `clr` for 1 cycle during data bit 4 of 0xFF. Expect all outputs 0 on the next edge. A following frame 0x5A is received correctly with no errors.
